// File: rtl/sun2_dcp_pkg.sv
// rtl/sun2_dcp_pkg.sv - shared types and constants for the DCP port arbiter
package sun2_dcp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_ADDR,
        ST_WAIT,
        ST_DATA,
        ST_ACK,
        ST_RECOVER
    } dcp_arb_state_t;

    localparam int REQ_CPU = 0;
    localparam int REQ_DMA = 1;
    localparam int CNT_W   = 4;
    localparam int TO_W    = 7;

endpackage

// File: rtl/dcp_strobe_timer.sv
// rtl/dcp_strobe_timer.sv - loadable down-counter; done while the count sits at zero
module dcp_strobe_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         enable,
    output logic         done
);

    logic [W-1:0] cnt;

    // Saturates at zero so done stays high until the next load.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/dcp_arbiter.sv
// rtl/dcp_arbiter.sv - two-requester DCP port arbiter and strobe sequencer; optional DCP_ARB_TIMEOUT_EN
module dcp_arbiter
    import sun2_dcp_pkg::*;
#(
    parameter int WAIT_CYC    = 2,
    parameter int STROBE_CYC  = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sanity_n,
    input  logic [1:0] req,
    input  logic [1:0] req_rd,
    input  logic [1:0] req_wr,
    input  logic [1:0] req_la1,
    input  logic       dcp_ready,
    output logic [1:0] gnt,
    output logic [1:0] ack,
    output logic       dcp_mas,
    output logic       dcp_mds,
    output logic       dcp_rd,
    output logic       busy,
    output logic       err
);

    // Timers count down to zero, so load one less than the wanted cycle count.
    localparam logic [CNT_W-1:0] WAIT_LD   = CNT_W'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'((STROBE_CYC > 1) ? STROBE_CYC - 1 : 0);

    dcp_arb_state_t   state, state_nx;
    logic             ptr;
    logic             win;
    logic             rd_l;
    logic             la1_l;
    logic             to_flag;
    logic             to_hit;
    logic [1:0]       req_ok;
    logic             pick;
    logic [1:0]       win_oh;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_en;
    logic             tmr_done;
    logic             to_done;

    assign req_ok         = req & (req_rd | req_wr);
    assign win_oh[REQ_CPU] = ~win;
    assign win_oh[REQ_DMA] = win;
    assign tmr_en         = (state == ST_WAIT) || (state == ST_DATA);

    always_comb begin
        if (req_ok == 2'b11) begin
            pick = ptr;
        end else if (req_ok[REQ_CPU]) begin
            pick = 1'b0;
        end else begin
            pick = 1'b1;
        end
    end

    dcp_strobe_timer #(.W(CNT_W)) u_strobe_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (tmr_load),
        .value   (tmr_value),
        .enable  (tmr_en),
        .done    (tmr_done)
    );

`ifdef DCP_ARB_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LD = TO_W'((TIMEOUT_CYC > 1) ? TIMEOUT_CYC - 1 : 0);

    // Held loaded outside DATA so it starts counting on the first mds cycle.
    dcp_strobe_timer #(.W(TO_W)) u_timeout_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (state != ST_DATA),
        .value   (TO_LD),
        .enable  (state == ST_DATA),
        .done    (to_done)
    );
`else
    logic unused_timeout;
    assign to_done        = 1'b0;
    assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            ptr     <= 1'b0;
            win     <= 1'b0;
            rd_l    <= 1'b0;
            la1_l   <= 1'b0;
            to_flag <= 1'b0;
        end else if (!sanity_n) begin
            state   <= ST_IDLE;
            to_flag <= 1'b0;
        end else begin
            state   <= state_nx;
            to_flag <= to_hit;
            if ((state == ST_IDLE) && (state_nx == ST_GRANT)) begin
                win   <= pick;
                ptr   <= ~pick;
                rd_l  <= req_rd[pick];
                la1_l <= req_la1[pick];
            end
        end
    end

    always_comb begin
        state_nx  = state;
        gnt       = 2'b00;
        ack       = 2'b00;
        dcp_mas   = 1'b0;
        dcp_mds   = 1'b0;
        dcp_rd    = 1'b0;
        busy      = (state != ST_IDLE);
        err       = 1'b0;
        tmr_load  = 1'b0;
        tmr_value = STROBE_LD;
        to_hit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|req_ok) state_nx = ST_GRANT;
            end
            ST_GRANT: begin
                gnt    = win_oh;
                dcp_rd = rd_l;
                if (la1_l) begin
                    state_nx = ST_ADDR;
                end else if (WAIT_CYC == 0) begin
                    state_nx = ST_DATA;
                    tmr_load = 1'b1;
                end else begin
                    state_nx  = ST_WAIT;
                    tmr_load  = 1'b1;
                    tmr_value = WAIT_LD;
                end
            end
            ST_ADDR: begin
                gnt      = win_oh;
                dcp_rd   = rd_l;
                dcp_mas  = 1'b1;
                state_nx = ST_ACK;
            end
            ST_WAIT: begin
                gnt    = win_oh;
                dcp_rd = rd_l;
                if (tmr_done) begin
                    state_nx = ST_DATA;
                    tmr_load = 1'b1;
                end
            end
            ST_DATA: begin
                gnt     = win_oh;
                dcp_rd  = rd_l;
                dcp_mds = 1'b1;
                if (tmr_done && dcp_ready) begin
                    state_nx = ST_ACK;
                end else if (to_done) begin
                    state_nx = ST_ACK;
                    to_hit   = 1'b1;
                end
            end
            ST_ACK: begin
                gnt      = win_oh;
                dcp_rd   = rd_l;
                ack      = win_oh;
                err      = to_flag;
                state_nx = ST_RECOVER;
            end
            ST_RECOVER: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcp_arbiter.sv
// tb/tb_dcp_arbiter.sv - directed vector bench for dcp_arbiter
module tb_dcp_arbiter;

    logic       clk = 1'b0;
    logic       reset_n, sanity_n, dcp_ready;
    logic [1:0] req, req_rd, req_wr, req_la1;
    logic [1:0] gnt, ack;
    logic       dcp_mas, dcp_mds, dcp_rd, busy, err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dcp_arbiter #(
        .WAIT_CYC    (2),
        .STROBE_CYC  (2),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sanity_n  (sanity_n),
        .req       (req),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .req_la1   (req_la1),
        .dcp_ready (dcp_ready),
        .gnt       (gnt),
        .ack       (ack),
        .dcp_mas   (dcp_mas),
        .dcp_mds   (dcp_mds),
        .dcp_rd    (dcp_rd),
        .busy      (busy),
        .err       (err)
    );

    typedef struct {
        logic       rst_n;
        logic       san_n;
        logic [1:0] rq, rd, wr, la1;
        logic       rdy;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst_n, logic san_n, logic [1:0] rq, logic [1:0] rd,
                                logic [1:0] wr, logic [1:0] la1, logic rdy, logic [1:0] g,
                                logic [1:0] a, logic m, logic d, logic r, logic b, logic e);
        vec_t v;
        v.rst_n = rst_n; v.san_n = san_n; v.rq = rq; v.rd = rd; v.wr = wr;
        v.la1 = la1; v.rdy = rdy; v.exp = {g, a, m, d, r, b, e};
        return v;
    endfunction

    function automatic logic [8:0] outs();
        return {gnt, ack, dcp_mas, dcp_mds, dcp_rd, busy, err};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    task automatic drive(input logic [1:0] rq, input logic [1:0] rd, input logic [1:0] wr,
                         input logic [1:0] la1);
        req = rq; req_rd = rd; req_wr = wr; req_la1 = la1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 2'b00);
        step();
        reset_n = 1'b1;
    endtask

    task automatic wait_mds(input string name);
        for (int i = 0; i < 12; i++) begin
            step();
            if (dcp_mds) break;
        end
        chk(name, {15'd0, dcp_mds}, 16'd1);
    endtask

    int         gc[4];
    logic [1:0] gv[4];
    int         n;
    logic [1:0] prev;

    initial begin
        reset_n = 1'b0; sanity_n = 1'b1; dcp_ready = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 2'b00);

        //           rst san req   rd    wr    la1  rdy  gnt   ack   mas mds rd busy err
        vecs.push_back(mk(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 2'b01, 2'b00, 2'b00, 2'b01, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 2'b01, 2'b00, 2'b01, 2'b01, 1, 2'b01, 2'b00, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b01, 2'b00, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b01, 2'b01, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 2'b10, 2'b10, 2'b10, 2'b00, 1, 2'b10, 2'b00, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 1, 2'b10, 2'b10, 2'b10, 2'b00, 1, 2'b10, 2'b00, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 1, 2'b10, 2'b10, 2'b10, 2'b00, 1, 2'b10, 2'b00, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 1, 2'b10, 2'b10, 2'b10, 2'b00, 1, 2'b10, 2'b00, 0, 1, 1, 1, 0));
        vecs.push_back(mk(1, 1, 2'b10, 2'b10, 2'b10, 2'b00, 1, 2'b10, 2'b00, 0, 1, 1, 1, 0));
        vecs.push_back(mk(1, 1, 2'b10, 2'b10, 2'b10, 2'b00, 1, 2'b10, 2'b10, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            reset_n = vecs[i].rst_n; sanity_n = vecs[i].san_n; dcp_ready = vecs[i].rdy;
            drive(vecs[i].rq, vecs[i].rd, vecs[i].wr, vecs[i].la1);
            step();
            chk($sformatf("vec%0d", i), {7'd0, outs()}, {7'd0, vecs[i].exp});
        end

        // Contention: both requesters valid continuously from reset.
        do_reset();
        drive(2'b11, 2'b00, 2'b11, 2'b11);
        n = 0; prev = 2'b00;
        for (int k = 0; k < 4; k++) begin gc[k] = 0; gv[k] = 2'b00; end
        for (int c = 1; c <= 40; c++) begin
            step();
            if ((gnt != 2'b00) && (prev == 2'b00) && (n < 4)) begin
                gc[n] = c; gv[n] = gnt; n++;
            end
            prev = gnt;
        end
        chk("cont_count", 16'(n), 16'd4);
        chk("cont_g0", {14'd0, gv[0]}, 16'h1);
        chk("cont_g1", {14'd0, gv[1]}, 16'h2);
        chk("cont_g2", {14'd0, gv[2]}, 16'h1);
        chk("cont_g3", {14'd0, gv[3]}, 16'h2);
        for (int k = 1; k < 4; k++)
            chk($sformatf("cont_gap%0d", k), 16'(gc[k] - gc[k-1]), 16'd5);

        // Ready stall: ready low for the first 10 mds cycles.
        do_reset();
        dcp_ready = 1'b0;
        drive(2'b10, 2'b10, 2'b00, 2'b00);
        wait_mds("stall_reach");
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("stall_mds%0d", k), {14'd0, ack, dcp_mds, dcp_rd}, 16'b0011);
        end
        dcp_ready = 1'b1;
        step();
        chk("stall_ack", {13'd0, ack, dcp_mds}, 16'b100);
        drive(2'b00, 2'b00, 2'b00, 2'b00);
        step(); step();

        // Sanity abort in DATA keeps the pointer (CPU just won, so DMA is favoured).
        do_reset();
        drive(2'b01, 2'b01, 2'b00, 2'b00);
        wait_mds("san_reach");
        sanity_n = 1'b0;
        step();
        chk("san_abort", {7'd0, outs()}, 16'd0);
        sanity_n = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 2'b00);
        step();
        chk("san_idle", {7'd0, outs()}, 16'd0);
        drive(2'b11, 2'b00, 2'b11, 2'b11);
        step();
        chk("san_ptr_kept", {14'd0, gnt}, 16'h2);
        step(); step();
        chk("san_next_ack", {14'd0, ack}, 16'h2);
        drive(2'b00, 2'b00, 2'b00, 2'b00);
        step(); step();
        chk("san_done", {15'd0, busy}, 16'd0);

        // Reset abort in DATA returns the pointer to requester 0.
        drive(2'b01, 2'b01, 2'b00, 2'b00);
        wait_mds("rst_reach");
        reset_n = 1'b0;
        step();
        chk("rst_abort", {7'd0, outs()}, 16'd0);
        reset_n = 1'b1;
        drive(2'b11, 2'b00, 2'b11, 2'b11);
        step();
        chk("rst_ptr_zero", {14'd0, gnt}, 16'h1);
        drive(2'b00, 2'b00, 2'b00, 2'b00);
        step(); step(); step(); step();

        // Ready never asserted.
        do_reset();
        dcp_ready = 1'b0;
        drive(2'b10, 2'b10, 2'b00, 2'b00);
        wait_mds("to_reach");
`ifdef DCP_ARB_TIMEOUT_EN
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("to_wait%0d", k), {13'd0, ack, err}, 16'd0);
        end
        step();
        chk("to_ack_err", {13'd0, ack, err}, 16'b101);
`else
        for (int k = 1; k <= 20; k++) step();
        chk("to_stuck", {13'd0, dcp_mds, err, busy}, 16'b101);
`endif
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcp_arbiter.md
Name: dcp_arbiter

Overview:
- Arbitrates two requesters for the single DCP port on the Sun-2 120 CPU board:
  - requester 0: CPU
  - requester 1: DMA/diagnostic engine
- Sequences each granted access into the DCP strobe protocol:
  - address phase (mas), or
  - wait + data phase (mds) with device ready.
- Returns a one-cycle ack to the winner.
- Sits between the CPU/DMA decode logic and the DCP address/data registers; it is the parameterised successor to the fixed-timing DCP control PAL.

Parameters:
- WAIT_CYC, 2: cycles between grant and mds assertion on data accesses; range 0..15; 0 skips WAIT.
- STROBE_CYC, 2: minimum mds width in cycles; range 1..15; a value of 0 is treated as 1.
- TIMEOUT_CYC, 64: cycles of mds without ready before forced abort (optional feature only).

Ports:
- clk  in  1  board clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- sanity_n  in  1  synchronous abort, active-low; watchdog/sanity line.
- req  in  2  per-requester access request; held until ack.
- req_rd  in  2  per-requester read qualifier.
- req_wr  in  2  per-requester write qualifier.
- req_la1  in  2  per-requester address-line 1: 1 = address register (mas), 0 = data register (mds).
- dcp_ready  in  1  DCP device ready during data phase.
- gnt  out  2  one-hot grant, held for the whole access.
- ack  out  2  one-cycle completion pulse to the granted requester.
- dcp_mas  out  1  address strobe, active-high.
- dcp_mds  out  1  data strobe, active-high.
- dcp_rd  out  1  direction of current access: 1 = read.
- busy  out  1  FSM not in IDLE.
- err  out  1  one-cycle timeout pulse, coincident with ack.

Behaviour:
- Reset: reset_n low at a posedge forces, at that edge:
  - state IDLE;
  - gnt=0, ack=0, dcp_mas=0, dcp_mds=0, dcp_rd=0, busy=0, err=0;
  - round-robin pointer = 0 (requester 0 favoured).
- Reset mid-access: aborts at that edge; no ack is issued.
- Sanity: sanity_n low has the same effect as reset, except the round-robin pointer is kept.
- Valid request: req[i]=1 and (req_rd[i] or req_wr[i]). A req with neither qualifier is ignored. If both are set, rd wins.
- States: IDLE, GRANT, ADDR, WAIT, DATA, ACK, RECOVER.
  - IDLE:
    - Any valid request -> GRANT.
    - Both valid -> the requester named by the pointer wins; the pointer then points to the loser.
    - Single valid request -> that requester wins; the pointer moves to the other requester.
  - GRANT:
    - gnt[w]=1; latch rd and la1 of the winner.
    - la1=1 -> ADDR.
    - la1=0 -> WAIT, or DATA if WAIT_CYC=0.
  - ADDR: dcp_mas=1 for exactly 1 cycle -> ACK.
  - WAIT: count WAIT_CYC cycles -> DATA.
  - DATA:
    - dcp_mds=1.
    - Exit to ACK when at least STROBE_CYC cycles have elapsed AND dcp_ready is sampled 1.
  - ACK: ack[w]=1 for 1 cycle; strobes 0 -> RECOVER.
  - RECOVER: 1 dead cycle; gnt cleared -> IDLE.
- gnt stays asserted from GRANT through ACK inclusive. dcp_rd is valid in the same window and 0 otherwise.
- Latency, address access: request sampled at edge 0 -> gnt edge 1 -> mas edge 2 -> ack edge 3 -> IDLE edge 5.
- Latency, data access (defaults, ready always 1): gnt 1, WAIT 2-3, mds 4-5, ack 6, RECOVER 7.
- req dropped mid-access: the access still completes and ack pulses (the requester discards it).
- req still held after ack: treated as a new request only once IDLE is re-entered.
- Requester inputs are ignored outside IDLE; only the latched copies are used.
- dcp_mas and dcp_mds are never high in the same cycle.

Optional Feature:
- Macro: DCP_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in DATA.
  - If dcp_ready has not been seen after TIMEOUT_CYC cycles of mds, go to ACK with err=1 alongside ack.
- Undefined: DATA waits indefinitely for ready; err is tied 0; the port is still present.

Decomposition:
- Package sun2_dcp_pkg holds:
  - state enum dcp_arb_state_t;
  - requester index constants REQ_CPU=0, REQ_DMA=1;
  - counter width constant CNT_W=4;
  - timeout width TO_W=7.
- Sub-module dcp_strobe_timer: loadable down-counter shared by WAIT, DATA-minimum and timeout.
  - Inputs: load, value, enable.
  - Output: done.

Test Plan:
- Address write, CPU only: req[0]=1, wr=1, la1=1 at edge 0 -> gnt=01 edges 1-3, mas=1 at edge 2 only, ack[0] at edge 3, busy low at edge 5.
- Data read, defaults, ready tied 1: req[1], rd, la1=0 -> mds edges 4-5, dcp_rd=1, ack[1] at edge 6.
- Contention: both requesters continuously valid from reset -> grants alternate 0,1,0,1 over 4 accesses, 5 cycles apart for address accesses.
- Ready stall: data access, dcp_ready held 0 for 10 cycles after mds rises -> mds high 10 cycles, ack exactly 1 cycle after ready is sampled 1.
- sanity_n pulsed low during DATA -> all strobes and gnt 0 at the next edge, no ack, next access served normally. Repeat with reset_n -> same outputs, and the pointer returns to 0.
- With DCP_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, ready never asserted -> ack and err together 8 cycles after mds rises. Without the macro, err stays 0 and the FSM stays in DATA.
